// File: rtl/text_writer.sv
// text_writer: streams one ASCII code per clock into the text tile RAM for
// "draw string N at (col,row)" commands. Strings come from a fixed message
// ROM or from the live 4-digit BCD score. A string that runs past the last
// column is cut off at the end of that row; it never continues on the next row.
//
// Handshake: a command is taken on a clock edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE. The command fields and score_bcd are
// captured on that edge and are not looked at again until the command
// finishes. cmd_valid is ignored while busy, and commands are never queued.
module text_writer #(
  parameter int COLS   = 28,
  parameter int ROWS   = 36,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_str_id,
  input  logic [4:0]        cmd_col,
  input  logic [5:0]        cmd_row,
  input  logic              cmd_erase,
  input  logic [15:0]       score_bcd,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

  // Message ROM, each string right-aligned in a 23-character field.
  localparam logic [183:0] MSG0 = {104'd0, "LOADING..."};
  localparam logic [183:0] MSG1 = {136'd0, "READY!"};
  localparam logic [183:0] MSG2 = "PRESS ANY KEY TO START!";
  localparam logic [183:0] MSG3 = {104'd0, "HIGH SCORE"};
  localparam logic [183:0] MSG4 = {96'd0,  "YOU LOST :("};

  localparam logic [5:0]        ROWS_W   = 6'(ROWS);
  localparam logic [5:0]        COLS_W   = 6'(COLS);
  localparam logic [4:0]        COL_LAST = 5'(COLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  // Character i of a right-aligned string of length len. The first character
  // of the string is in the highest byte.
  function automatic logic [7:0] pick(input logic [183:0] s, input logic [4:0] len,
                                      input logic [4:0] i);
    logic [7:0] pos;
    pick = 8'h00;
    if (i < len) begin
      pos  = {len - 5'd1 - i, 3'b000};
      pick = s[pos +: 8];
    end
  endfunction

  // Number of characters in each string ID.
  function automatic logic [5:0] len_of(input logic [2:0] id);
    case (id)
      3'd0:    len_of = 6'd10;
      3'd1:    len_of = 6'd6;
      3'd2:    len_of = 6'd23;
      3'd3:    len_of = 6'd10;
      3'd4:    len_of = 6'd11;
      3'd5:    len_of = 6'd4;
      3'd6:    len_of = COLS_W;
      default: len_of = 6'd0;
    endcase
  endfunction

  // ASCII code written at position idx of a string. Erase writes spaces.
  function automatic logic [7:0] char_of(input logic [2:0] id, input logic erase,
                                         input logic [15:0] score, input logic [4:0] idx);
    logic [3:0] nib;
    char_of = 8'h00;
    if (erase) begin
      char_of = 8'h20;
    end else begin
      case (id)
        3'd0: char_of = pick(MSG0, 5'd10, idx);
        3'd1: char_of = pick(MSG1, 5'd6,  idx);
        3'd2: char_of = pick(MSG2, 5'd23, idx);
        3'd3: char_of = pick(MSG3, 5'd10, idx);
        3'd4: char_of = pick(MSG4, 5'd11, idx);
        3'd5: begin
          case (idx[1:0])
            2'd0:    nib = score[15:12];
            2'd1:    nib = score[11:8];
            2'd2:    nib = score[7:4];
            default: nib = score[3:0];
          endcase
          char_of = 8'd48 + {4'h0, nib};
        end
        3'd6:    char_of = 8'h20;
        default: char_of = 8'h00;
      endcase
    end
  endfunction

  state_t              state, state_n;
  logic [4:0]          idx, idx_n;
  logic [4:0]          cur_col, cur_col_n;
  logic [2:0]          id_q, id_n;
  logic                erase_q, erase_n;
  logic [15:0]         score_q, score_n;
  logic [ADDR_W-1:0]   base_q, base_n;
  logic                wr_en_n, done_n;
  logic [ADDR_W-1:0]   wr_addr_n;
  logic [7:0]          wr_data_n;
  logic [ADDR_W-1:0]   cmd_base;
  logic                cmd_empty;
  logic                last_char;
  logic [4:0]          idx_inc;

  assign cmd_base  = ADDR_W'(cmd_row) * COLS_A + ADDR_W'(cmd_col);
  assign cmd_empty = (len_of(cmd_str_id) == 6'd0) || (cmd_row >= ROWS_W) ||
                     ({1'b0, cmd_col} >= COLS_W);
  assign last_char = (({1'b0, idx} + 6'd1) == len_of(id_q)) || (cur_col == COL_LAST);
  assign idx_inc   = idx + 5'd1;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // State, command context and registered RAM-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      cur_col <= '0;
      id_q    <= '0;
      erase_q <= 1'b0;
      score_q <= '0;
      base_q  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cur_col <= cur_col_n;
      id_q    <= id_n;
      erase_q <= erase_n;
      score_q <= score_n;
      base_q  <= base_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      done    <= done_n;
    end
  end

  // Next state, plus the outputs for the next cycle, so the first write
  // appears in the cycle right after the handshake.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cur_col_n = cur_col;
    id_n      = id_q;
    erase_n   = erase_q;
    score_n   = score_q;
    base_n    = base_q;
    wr_en_n   = 1'b0;
    done_n    = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          id_n      = cmd_str_id;
          erase_n   = cmd_erase;
          score_n   = score_bcd;
          base_n    = cmd_base;
          idx_n     = 5'd0;
          cur_col_n = cmd_col;
          if (cmd_empty) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n   = S_WRITE;
            wr_en_n   = 1'b1;
            wr_addr_n = cmd_base;
            wr_data_n = char_of(cmd_str_id, cmd_erase, score_bcd, 5'd0);
          end
        end
      end
      S_WRITE: begin
        if (last_char) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          idx_n     = idx_inc;
          cur_col_n = cur_col + 5'd1;
          wr_en_n   = 1'b1;
          wr_addr_n = base_q + ADDR_W'(idx_inc);
          wr_data_n = char_of(id_q, erase_q, score_q, idx_inc);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: directed cases plus random commands. Expected writes
// come from a string-table model and are queued in exp_q.
module tb_text_writer;
  localparam int COLS   = 28;
  localparam int ROWS   = 36;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_str_id = '0;
  logic [4:0]        cmd_col = '0;
  logic [5:0]        cmd_row = '0;
  logic              cmd_erase = 1'b0;
  logic [15:0]       score_bcd = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] exp_q[$];

  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_str_id(cmd_str_id), .cmd_col(cmd_col), .cmd_row(cmd_row),
    .cmd_erase(cmd_erase), .score_bcd(score_bcd), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the string table and the clipping rule.
  function automatic string ref_msg(input int id);
    case (id)
      0: return "LOADING...";
      1: return "READY!";
      2: return "PRESS ANY KEY TO START!";
      3: return "HIGH SCORE";
      4: return "YOU LOST :(";
      default: return "";
    endcase
  endfunction

  function automatic int ref_len(input int id);
    if (id <= 4) return ref_msg(id).len();
    if (id == 5) return 4;
    if (id == 6) return COLS;
    return 0;
  endfunction

  function automatic logic [7:0] ref_char(input int id, input bit erase,
                                          input logic [15:0] score, input int k);
    string s;
    if (erase) return 8'h20;
    if (id <= 4) begin
      s = ref_msg(id);
      return s[k];
    end
    if (id == 5) return 8'(48 + ((score >> (4 * (3 - k))) & 16'hF));
    return 8'h20;
  endfunction

  task automatic build(input int id, input int col, input int row, input bit erase,
                       input logic [15:0] score);
    int n;
    if (row >= ROWS || col >= COLS) return;
    n = ref_len(id);
    if (n > COLS - col) n = COLS - col;
    for (int k = 0; k < n; k++)
      exp_q.push_back({10'(row * COLS + col + k), ref_char(id, erase, score, k)});
  endtask

  task automatic drive(input int id, input int col, input int row, input bit erase,
                       input logic [15:0] score);
    cmd_str_id = 3'(id);
    cmd_col    = 5'(col);
    cmd_row    = 6'(row);
    cmd_erase  = erase;
    score_bcd  = score;
  endtask

  // One command from IDLE, checking every cycle until cmd_ready returns.
  task automatic run_cmd(input string tag, input int id, input int col, input int row,
                         input bit erase, input logic [15:0] score);
    int n;
    logic [17:0] e;
    logic [17:0] last_e;
    @(negedge clk);
    check({tag, "_ready0"}, {31'd0, cmd_ready}, 32'd1);
    drive(id, col, row, erase, score);
    cmd_valid = 1'b1;
    exp_q.delete();
    build(id, col, row, erase, score);
    n = exp_q.size();
    last_e = '0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    score_bcd = 16'h9999;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      last_e = e;
      check({tag, "_wren"}, {31'd0, wr_en}, 32'd1);
      check({tag, "_wr"}, {14'd0, wr_addr, wr_data}, {14'd0, e});
      check({tag, "_busy"}, {30'd0, busy, cmd_ready}, 32'd2);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"}, {30'd0, done, wr_en}, 32'd2);
    check({tag, "_donebusy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_after"}, {29'd0, done, cmd_ready, busy}, 32'd2);
    if (n > 0) check({tag, "_hold"}, {14'd0, wr_addr, wr_data}, {14'd0, last_e});
  endtask

  initial begin
    int ids[4];
    int p, accepted, dones, cyc;
    logic [17:0] e;
    ids = '{1, 7, 5, 0};

    // Reset state.
    #12;
    check("rst_out", {wr_en, done, busy, wr_data, 22'(wr_addr)}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // Directed cases.
    run_cmd("ready", 1, 13, 17, 1'b0, 16'h0000);
    run_cmd("score", 5, 5, 1, 1'b0, 16'h0427);
    run_cmd("clip", 2, 20, 2, 1'b0, 16'h0000);
    run_cmd("erase", 4, 13, 17, 1'b1, 16'h0000);
    run_cmd("row_oor", 0, 0, 36, 1'b0, 16'h0000);
    run_cmd("col_oor", 1, 28, 0, 1'b0, 16'h0000);
    run_cmd("id7", 7, 3, 3, 1'b0, 16'h0000);
    run_cmd("blank", 6, 0, 35, 1'b0, 16'h0000);

    // Reset during the third write of "HIGH SCORE".
    @(negedge clk);
    drive(3, 0, 3, 1'b0, 16'h0000);
    cmd_valid = 1'b1;
    exp_q.delete();
    build(3, 0, 3, 1'b0, 16'h0000);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("rstmid_wr", {13'd0, wr_en, wr_addr, wr_data}, {13'd1, e});
    end
    #1;
    rst = 1'b1;
    #1;
    check("rstmid_out", {wr_en, done, busy, wr_data, 22'(wr_addr)}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rstmid_nodone", {30'd0, done, wr_en}, 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", {30'd0, cmd_ready, done}, 32'd2);
    run_cmd("post_rst", 1, 13, 17, 1'b0, 16'h0000);

    // Random commands, some out of range.
    for (int r = 0; r < 25; r++)
      run_cmd("rand", $urandom_range(0, 7), $urandom_range(0, 31),
              $urandom_range(0, 39), 1'($urandom_range(0, 1)), 16'($urandom));

    // cmd_valid held high, ids cycled; scoreboard checks the write stream.
    exp_q.delete();
    p = 0;
    accepted = 0;
    dones = 0;
    @(negedge clk);
    drive(ids[0], $urandom_range(0, 27), $urandom_range(0, 35), 1'b0, 16'($urandom));
    cmd_valid = 1'b1;
    for (cyc = 0; cyc < 160; cyc++) begin
      if (cyc == 120) cmd_valid = 1'b0;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("cont_spurious", {31'd0, wr_en}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("cont_wr", {14'd0, wr_addr, wr_data}, {14'd0, e});
        end
      end
      check("cont_overlap", {31'd0, wr_en & cmd_ready}, 32'd0);
      if (done) dones++;
      if (cmd_valid && cmd_ready) begin
        accepted++;
        build(int'(cmd_str_id), int'(cmd_col), int'(cmd_row), cmd_erase, score_bcd);
        @(posedge clk);
        #1;
        p = (p + 1) % 4;
        drive(ids[p], $urandom_range(0, 27), $urandom_range(0, 35),
              1'($urandom_range(0, 1)), 16'($urandom));
      end else begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
    end
    check("cont_dones", 32'(dones), 32'(accepted));
    check("cont_drained", 32'(exp_q.size()), 32'd0);
    check("cont_some", {31'd0, accepted > 8}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
